dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data memory between the core's load/store path (port 0) and a secondary master such as a program loader or debug port (port 1). It selects one requester per cycle, drives the memory's byte-enable/address/data inputs from the winner, and routes the one-cycle-latency read data back with a per-port valid. It supports short locked bursts, bounded by a watchdog, so one master can hold the memory for multi-word sequences. It sits between the core datapath and `data_memory`; the core stalls on `gnt0 == 0`.

---
 rtl/dmem_arb_pkg.sv | 27 ++
 rtl/dmem_arbiter_lock_watchdog.sv | 47 ++++
 rtl/dmem_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared types and constants for the data-memory arbiter slice.
//   - arb_state_t : arbiter FSM state (IDLE, LOCK0, LOCK1)
//   - port_idx_t  : index of a requesting port (0 = core load/store,
//                   1 = secondary master such as a loader or debug port)
//   - DEFAULT_LOCK_MAX : default bound on how long a lock may starve the
//                   other port
//   - other_port() : the port that is not the given one
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef logic port_idx_t;

  localparam int DEFAULT_LOCK_MAX = 16;

  function automatic port_idx_t other_port(input port_idx_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/dmem_arbiter_lock_watchdog.sv
// ---------------------------------------------------------------------------
// lock_watchdog
//   Saturating cycle counter that bounds how long a locked owner may keep
//   the memory while the other port is waiting.
//
//   Ports
//     clk     in   clock
//     reset   in   asynchronous active-high reset (count -> 0)
//     clear   in   synchronous clear; wins over enable
//     enable  in   count one cycle of waiting
//     tc      out  terminal count reached (count == LOCK_MAX-1)
//
//   Parameter
//     LOCK_MAX  number of waiting cycles after which the lock is broken (>= 2)
// ---------------------------------------------------------------------------
module lock_watchdog
  import dmem_arb_pkg::*;
#(
  parameter int LOCK_MAX = DEFAULT_LOCK_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = $clog2(LOCK_MAX);
  localparam logic [CW-1:0] TERM = CW'(LOCK_MAX - 1);

  logic [CW-1:0] count;

  // The counter stops at the terminal value so tc stays asserted until the
  // owner clears it by leaving the locked state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TERM);

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-ported data memory between the core load/store path
//   (port 0) and a secondary master (port 1). One requester is selected per
//   cycle; its byte enables, address and write data are driven to the
//   memory. Read data returns one cycle later with a per-port valid.
//   A master may lock the memory for a multi-word sequence; a watchdog
//   breaks a lock that starves the other port for LOCK_MAX cycles.
//
//   Handshake: reqN is the request, gntN is the acceptance. An access is
//   transferred in every cycle where reqN & gntN. gntN is combinational from
//   req/lock state only (never from mem_rdata); a master seeing gntN = 0
//   holds its request and stalls. At most one gnt is high per cycle.
//
//   Ports
//     clk, reset            clock, asynchronous active-high reset
//     req0/1, lock0/1       request, keep ownership after this access
//     we0/1 [3:0]           byte write enables (0000 = read)
//     addr0/1, wdata0/1     word address and lane-aligned write data
//     gnt0/1                access accepted this cycle
//     rvalid0/1             read data valid (cycle after an accepted read)
//     rdata0/1              read data (mem_rdata pass-through)
//     mem_we/addr/wdata     to data memory
//     mem_rdata             from data memory, one cycle after address
//     lock_timeout          one-cycle pulse after a lock is forcibly broken
//     dbg_state             current arbiter state, for observation
//
//   Configuration macro
//     ARB_ROUND_ROBIN_EN    defined: IDLE ties go to the port not granted
//                           most recently. Undefined: port 0 wins ties.
//                           In both builds the waiting port wins the first
//                           tie after a watchdog release.
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_MAX   = DEFAULT_LOCK_MAX
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req0,
  input  logic                  lock0,
  input  logic [3:0]            we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,

  input  logic                  req1,
  input  logic                  lock1,
  input  logic [3:0]            we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,

  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,

  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,

  output logic                  lock_timeout,
  output arb_state_t            dbg_state
);

  arb_state_t state;

  // After a watchdog release the starved port must win the next tie,
  // regardless of the configured policy.
  logic       force_valid;
  port_idx_t  force_port;

  port_idx_t  policy_winner;
  port_idx_t  tie_winner;

  logic       wd_clear;
  logic       wd_enable;
  logic       wd_tc;

`ifdef ARB_ROUND_ROBIN_EN
  // Port granted most recently in IDLE (or the owner of a broken lock).
  port_idx_t  last_gnt;
  assign policy_winner = other_port(last_gnt);
`else
  assign policy_winner = 1'b0;
`endif

  assign tie_winner = force_valid ? force_port : policy_winner;

  // -------------------------------------------------------------------------
  // Grant selection
  // -------------------------------------------------------------------------
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          gnt0 = (tie_winner == 1'b0);
          gnt1 = (tie_winner == 1'b1);
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
      LOCK0:   gnt0 = req0;
      LOCK1:   gnt1 = req1;
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Memory request mux. With no grant the port-0 address/data are passed
  // through with mem_we = 0, so nothing is written.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_we    = 4'b0000;
    mem_addr  = addr0;
    mem_wdata = wdata0;
    if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end else if (gnt0) begin
      mem_we    = we0;
    end
  end

  // Read data goes to both ports; rvalidN tells which one asked for it.
  assign rdata0 = mem_rdata;
  assign rdata1 = mem_rdata;

  // -------------------------------------------------------------------------
  // Lock watchdog: held at zero while IDLE so it starts from zero on every
  // lock entry; counts only cycles in which the non-owner is requesting.
  // -------------------------------------------------------------------------
  assign wd_clear  = (state == IDLE);
  assign wd_enable = ((state == LOCK0) && req1) || ((state == LOCK1) && req0);

  lock_watchdog #(
    .LOCK_MAX (LOCK_MAX)
  ) u_lock_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .tc     (wd_tc)
  );

  // -------------------------------------------------------------------------
  // Arbiter FSM with registered read-valid and timeout outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rvalid0      <= 1'b0;
      rvalid1      <= 1'b0;
      lock_timeout <= 1'b0;
      force_valid  <= 1'b0;
      force_port   <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt     <= 1'b1;
`endif
    end else begin
      rvalid0      <= gnt0 && (we0 == 4'b0000);
      rvalid1      <= gnt1 && (we1 == 4'b0000);
      lock_timeout <= 1'b0;

      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            force_valid <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_gnt    <= gnt1;
`endif
          end
          if (gnt0 && lock0) begin
            state <= LOCK0;
          end else if (gnt1 && lock1) begin
            state <= LOCK1;
          end
        end

        LOCK0: begin
          // The owner still gets this cycle's access; the break takes
          // effect from the next cycle.
          if (wd_tc) begin
            state        <= IDLE;
            lock_timeout <= 1'b1;
            force_valid  <= 1'b1;
            force_port   <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_gnt     <= 1'b0;
`endif
          end else if (!lock0) begin
            state <= IDLE;
          end
        end

        LOCK1: begin
          if (wd_tc) begin
            state        <= IDLE;
            lock_timeout <= 1'b1;
            force_valid  <= 1'b1;
            force_port   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_gnt     <= 1'b1;
`endif
          end else if (!lock1) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a behavioural one-cycle-latency
//   data memory. Inputs change on the falling edge; combinational outputs
//   are sampled 1 ns later, registered outputs right at the falling edge.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LM = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          req0, lock0, req1, lock1;
  logic [3:0]    we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          lock_timeout;
  arb_state_t    dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // scoreboard of expected read data
  logic [DW-1:0] exp_q[$];

  dmem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LOCK_MAX   (LM)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req0         (req0),
    .lock0        (lock0),
    .we0          (we0),
    .addr0        (addr0),
    .wdata0       (wdata0),
    .req1         (req1),
    .lock1        (lock1),
    .we1          (we1),
    .addr1        (addr1),
    .wdata1       (wdata1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .rvalid0      (rvalid0),
    .rvalid1      (rvalid1),
    .rdata0       (rdata0),
    .rdata1       (rdata1),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .lock_timeout (lock_timeout),
    .dbg_state    (dbg_state)
  );

  // ---------------- memory model: word i resets to 0x1000_0000 | i ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'h1000_0000 | 32'(i);
      mem_rdata <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    req0 = 1'b0; lock0 = 1'b0; we0 = 4'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; lock1 = 1'b0; we1 = 4'b0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic drive_p0(input logic r, input logic l, input logic [3:0] w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0 = r; lock0 = l; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic drive_p1(input logic r, input logic l, input logic [3:0] w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1 = r; lock1 = l; we1 = w; addr1 = a; wdata1 = d;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    #1;
    tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL reset state: got %0d expected %0d", dbg_state, IDLE); end
    tests_run++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin tests_failed++; $display("FAIL reset rvalid: got %b%b expected 00", rvalid0, rvalid1); end
    tests_run++; if (lock_timeout !== 1'b0) begin tests_failed++; $display("FAIL reset lock_timeout: got %b expected 0", lock_timeout); end
    tests_run++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || mem_we !== 4'b0) begin tests_failed++; $display("FAIL reset idle outputs: gnt %b%b mem_we %b expected 00 0000", gnt0, gnt1, mem_we); end
  endtask

  task automatic test_single_read();
    logic [DW-1:0] exp;
    apply_reset();
    @(negedge clk);
    drive_p0(1'b1, 1'b0, 4'b0000, 10'd5, '0);
    exp_q.push_back(32'h1000_0005);
    #1;
    tests_run++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin tests_failed++; $display("FAIL single_read gnt: got %b%b expected 10", gnt0, gnt1); end
    tests_run++; if (mem_addr !== 10'd5 || mem_we !== 4'b0000) begin tests_failed++; $display("FAIL single_read mem: addr %0d we %b expected 5 0000", mem_addr, mem_we); end
    @(negedge clk);
    drive_idle();
    exp = exp_q.pop_front();
    tests_run++; if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0) begin tests_failed++; $display("FAIL single_read rvalid: got %b%b expected 10", rvalid0, rvalid1); end
    tests_run++; if (rdata0 !== exp) begin tests_failed++; $display("FAIL single_read rdata0: got %h expected %h", rdata0, exp); end
    tests_run++; if (rdata1 !== exp) begin tests_failed++; $display("FAIL single_read rdata1: got %h expected %h", rdata1, exp); end
    @(negedge clk);
    tests_run++; if (rvalid0 !== 1'b0) begin tests_failed++; $display("FAIL single_read rvalid0 drop: got %b expected 0", rvalid0); end
  endtask

  task automatic test_tie();
    logic exp1;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_p0(1'b1, 1'b0, 4'b0000, AW'(k), '0);
      drive_p1(1'b1, 1'b0, 4'b0000, AW'(k + 8), '0);
`ifdef ARB_ROUND_ROBIN_EN
      exp1 = (k % 2 == 1);
`else
      exp1 = 1'b0;
`endif
      #1;
      tests_run++; if (gnt0 !== ~exp1 || gnt1 !== exp1) begin tests_failed++; $display("FAIL tie cycle %0d gnt: got %b%b expected %b%b", k, gnt0, gnt1, ~exp1, exp1); end
      tests_run++; if (mem_addr !== (exp1 ? AW'(k + 8) : AW'(k))) begin tests_failed++; $display("FAIL tie cycle %0d mem_addr: got %0d expected %0d", k, mem_addr, exp1 ? k + 8 : k); end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_lock_write();
    logic [DW-1:0] exp;
    apply_reset();
    @(negedge clk);
    drive_p1(1'b1, 1'b1, 4'b0011, 10'd3, 32'hDEAD_BEEF);
    #1;
    tests_run++; if (gnt1 !== 1'b1 || mem_we !== 4'b0011 || mem_addr !== 10'd3 || mem_wdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL lock_write first: gnt1 %b we %b addr %0d wdata %h expected 1 0011 3 deadbeef", gnt1, mem_we, mem_addr, mem_wdata); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++; if (rvalid1 !== 1'b0) begin tests_failed++; $display("FAIL lock_write rvalid1 cycle %0d: got %b expected 0", k, rvalid1); end
      drive_p0(1'b1, 1'b0, 4'b0000, 10'd3, '0);
      if (k == 2) lock1 = 1'b0;
      #1;
      tests_run++; if (gnt0 !== 1'b0 || gnt1 !== 1'b1 || mem_we !== 4'b0011) begin tests_failed++; $display("FAIL lock_write hold cycle %0d: gnt %b%b we %b expected 01 0011", k, gnt0, gnt1, mem_we); end
      tests_run++; if (dbg_state !== LOCK1) begin tests_failed++; $display("FAIL lock_write state cycle %0d: got %0d expected %0d", k, dbg_state, LOCK1); end
    end
    @(negedge clk);
    drive_p1(1'b0, 1'b0, 4'b0000, '0, '0);
    exp_q.push_back(32'h1000_BEEF);
    #1;
    tests_run++; if (dbg_state !== IDLE || gnt0 !== 1'b1 || mem_we !== 4'b0000) begin tests_failed++; $display("FAIL lock_write release: state %0d gnt0 %b we %b expected 0 1 0000", dbg_state, gnt0, mem_we); end
    @(negedge clk);
    drive_idle();
    exp = exp_q.pop_front();
    tests_run++; if (rvalid0 !== 1'b1 || rdata0 !== exp) begin tests_failed++; $display("FAIL lock_write readback: rvalid0 %b rdata0 %h expected 1 %h", rvalid0, rdata0, exp); end
  endtask

  // owner == 1: port 1 holds the lock while port 0 waits; owner == 0: mirrored
  task automatic test_watchdog(input logic owner);
    apply_reset();
    @(negedge clk);
    if (owner) drive_p1(1'b1, 1'b1, 4'b0000, 10'd9, '0);
    else       drive_p0(1'b1, 1'b1, 4'b0000, 10'd9, '0);
    #1;
    tests_run++; if (gnt0 !== ~owner || gnt1 !== owner) begin tests_failed++; $display("FAIL watchdog%0d entry gnt: got %b%b expected %b%b", owner, gnt0, gnt1, ~owner, owner); end
    for (int k = 0; k < LM; k++) begin
      @(negedge clk);
      tests_run++; if (lock_timeout !== 1'b0) begin tests_failed++; $display("FAIL watchdog%0d early timeout cycle %0d: got %b expected 0", owner, k, lock_timeout); end
      if (owner) drive_p0(1'b1, 1'b0, 4'b0000, 10'd4, '0);
      else       drive_p1(1'b1, 1'b0, 4'b0000, 10'd4, '0);
      #1;
      tests_run++; if (gnt0 !== ~owner || gnt1 !== owner) begin tests_failed++; $display("FAIL watchdog%0d hold cycle %0d gnt: got %b%b expected %b%b", owner, k, gnt0, gnt1, ~owner, owner); end
    end
    @(negedge clk);
    tests_run++; if (lock_timeout !== 1'b1 || dbg_state !== IDLE) begin tests_failed++; $display("FAIL watchdog%0d release: timeout %b state %0d expected 1 0", owner, lock_timeout, dbg_state); end
    #1;
    tests_run++; if (gnt0 !== owner || gnt1 !== ~owner) begin tests_failed++; $display("FAIL watchdog%0d waiter gnt: got %b%b expected %b%b", owner, gnt0, gnt1, owner, ~owner); end
    @(negedge clk);
    drive_idle();
    tests_run++; if (lock_timeout !== 1'b0) begin tests_failed++; $display("FAIL watchdog%0d pulse width: got %b expected 0", owner, lock_timeout); end
  endtask

  task automatic test_lock_no_req();
    apply_reset();
    @(negedge clk);
    drive_p0(1'b0, 1'b1, 4'b0000, 10'd7, '0);
    #1;
    tests_run++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin tests_failed++; $display("FAIL lock_no_req gnt: got %b%b expected 00", gnt0, gnt1); end
    @(negedge clk);
    tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL lock_no_req state: got %0d expected %0d", dbg_state, IDLE); end
    drive_p0(1'b0, 1'b0, 4'b0000, '0, '0);
    drive_p1(1'b1, 1'b0, 4'b0000, 10'd6, '0);
    #1;
    tests_run++; if (gnt1 !== 1'b1) begin tests_failed++; $display("FAIL lock_no_req gnt1: got %b expected 1", gnt1); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(negedge clk);
    drive_p0(1'b1, 1'b1, 4'b0000, 10'd5, '0);
    #1;
    tests_run++; if (gnt0 !== 1'b1) begin tests_failed++; $display("FAIL reset_mid gnt0: got %b expected 1", gnt0); end
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    #1;
    tests_run++; if (rvalid0 !== 1'b0 || dbg_state !== IDLE || lock_timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_mid async: rvalid0 %b state %0d timeout %b expected 0 0 0", rvalid0, dbg_state, lock_timeout); end
    tests_run++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || mem_we !== 4'b0000) begin tests_failed++; $display("FAIL reset_mid outputs: gnt %b%b we %b expected 00 0000", gnt0, gnt1, mem_we); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin tests_failed++; $display("FAIL reset_mid late rvalid: got %b%b expected 00", rvalid0, rvalid1); end
    drive_p1(1'b1, 1'b0, 4'b0000, 10'd6, '0);
    #1;
    tests_run++; if (gnt1 !== 1'b1) begin tests_failed++; $display("FAIL reset_mid lock released gnt1: got %b expected 1", gnt1); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_we;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k > 0) begin
        tests_run++; if (rvalid0 !== ((k - 1) % 2 == 0) || rvalid1 !== 1'b0) begin tests_failed++; $display("FAIL b2b rvalid cycle %0d: got %b%b expected %b0", k, rvalid0, rvalid1, ((k - 1) % 2 == 0)); end
        if ((k - 1) % 2 == 0) begin
          tests_run++; if (rdata0 !== 32'h1000_0001) begin tests_failed++; $display("FAIL b2b rdata0 cycle %0d: got %h expected 10000001", k, rdata0); end
        end
      end
      if (k % 2 == 0) begin
        drive_p0(1'b1, 1'b0, 4'b0000, 10'd1, '0);
        drive_p1(1'b0, 1'b0, 4'b0000, '0, '0);
        exp_we = 4'b0000;
      end else begin
        drive_p0(1'b0, 1'b0, 4'b0000, '0, '0);
        drive_p1(1'b1, 1'b0, 4'b1111, 10'd2, 32'hCAFE_0002);
        exp_we = 4'b1111;
      end
      #1;
      tests_run++; if (mem_we !== exp_we) begin tests_failed++; $display("FAIL b2b mem_we cycle %0d: got %b expected %b", k, mem_we, exp_we); end
    end
    @(negedge clk);
    drive_idle();
    tests_run++; if (rvalid0 !== 1'b0) begin tests_failed++; $display("FAIL b2b rvalid0 after write: got %b expected 0", rvalid0); end
    tests_run++; if (mem[2] !== 32'hCAFE_0002) begin tests_failed++; $display("FAIL b2b written word: got %h expected cafe0002", mem[2]); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_single_read();
    test_tie();
    test_lock_write();
    test_watchdog(1'b1);
    test_watchdog(1'b0);
    test_lock_no_req();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
